// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte requesters; optional packet lock via UART_TX_ARB_LOCK_EN.
// One-entry output register: byte accepted at edge n is on tx_data after edge n; requesters stall while the register is full and tx_ready is low.
module uart_tx_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             tx_valid,
  output logic [WIDTH-1:0] tx_data,
  input  logic             tx_ready,
  output logic [1:0]       src
);

  typedef enum logic [1:0] {IDLE, HOLD0, HOLD1} state_t;

  state_t state, state_next;
  logic   prio;
  logic   room, cand0, cand1, win0, win1, acc0, acc1;

  always_comb begin
    room  = ~tx_valid | tx_ready;
    cand0 = req0_valid & (state != HOLD1);
    cand1 = req1_valid & (state != HOLD0);
    // A lone candidate wins outright; a tie goes to the priority pointer.
    win0  = cand0 & (~cand1 | ~prio);
    win1  = cand1 & (~cand0 |  prio);
    req0_ready = room & win0 & ~reset;
    req1_ready = room & win1 & ~reset;
    acc0  = req0_valid & req0_ready;
    acc1  = req1_valid & req1_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

`ifdef UART_TX_ARB_LOCK_EN
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (acc0 && !req0_last)      state_next = HOLD0;
        else if (acc1 && !req1_last) state_next = HOLD1;
      end
      HOLD0:   if (acc0 && req0_last) state_next = IDLE;
      HOLD1:   if (acc1 && req1_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
`else
  logic unused_last;
  assign unused_last = req0_last ^ req1_last;

  always_comb begin
    state_next = IDLE;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
      src      <= 2'b00;
      prio     <= 1'b0;
    end else if (acc0) begin
      tx_valid <= 1'b1;
      tx_data  <= req0_data;
      src      <= 2'b01;
      prio     <= 1'b1;
    end else if (acc1) begin
      tx_valid <= 1'b1;
      tx_data  <= req1_data;
      src      <= 2'b10;
      prio     <= 1'b0;
    end else if (tx_valid && tx_ready) begin
      // tx_data is left as-is once drained
      tx_valid <= 1'b0;
      src      <= 2'b00;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table for arbitration/handshake plus hand sequences, with a scoreboard on the tx side.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req0_data, req1_data, tx_data;
  logic       tx_valid, tx_ready;
  logic [1:0] src;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .src(src)
  );

  typedef struct packed { logic [7:0] dat; logic [1:0] src; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  typedef struct {
    logic       v0; logic [7:0] d0;
    logic       v1; logic [7:0] d1;
    logic       txr;
    logic       r0, r1, txv;
    logic [7:0] txd;
    logic [1:0] src;
  } vec_t;
  vec_t tbl[11];

  logic [7:0] s0_d[4], s1_d[4];
  logic       s0_l[4], s1_l[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp_v);
    end
  endtask

  // Scoreboard: every byte leaving the output register must match the next expected entry.
  always @(negedge clk) begin
    if (!reset && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got data %0h src %b, want no output", tx_data, src);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", {24'd0, tx_data}, {24'd0, mon_e.dat});
        check("out_src", {30'd0, src}, {30'd0, mon_e.src});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b1;
    req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b1;
    tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string tag);
    int cyc = 0;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; tx_ready = 1'b1;
    while ((tx_valid || exp_q.size() != 0) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_tx_empty"}, {31'd0, tx_valid}, 0);
  endtask

  task automatic run_streams(input int n0, input int n1, input string tag);
    int i0 = 0, i1 = 0, cyc = 0;
    while ((i0 < n0 || i1 < n1) && cyc < 50) begin
      @(posedge clk); #1;
      tx_ready   = 1'b1;
      req0_valid = (i0 < n0);
      req0_data  = (i0 < n0) ? s0_d[i0] : 8'h00;
      req0_last  = (i0 < n0) ? s0_l[i0] : 1'b1;
      req1_valid = (i1 < n1);
      req1_data  = (i1 < n1) ? s1_d[i1] : 8'h00;
      req1_last  = (i1 < n1) ? s1_l[i1] : 1'b1;
      @(negedge clk);
      check({tag, "_ready_onehot"}, {31'd0, req0_ready & req1_ready}, 0);
      if (req0_valid && req0_ready) i0++;
      if (req1_valid && req1_ready) i1++;
      cyc++;
    end
    check({tag, "_all_accepted"}, {31'd0, (i0 == n0) && (i1 == n1)}, 1);
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b1;
    req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b1;
    tx_ready = 1'b0;

    //            v0  d0     v1  d1     txr   r0 r1 txv txd    src
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};
    tbl[1]  = '{1'b1, 8'h41, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00};
    tbl[2]  = '{1'b1, 8'h42, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h41, 2'b01};
    tbl[3]  = '{1'b1, 8'h43, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h42, 2'b01};
    tbl[4]  = '{1'b1, 8'h44, 1'b1, 8'hA2, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA1, 2'b10};
    tbl[5]  = '{1'b1, 8'h45, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h44, 2'b01};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h44, 2'b01};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44, 2'b00};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 2'b00};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA4, 2'b10};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA4, 2'b00};

    do_reset();

    // Vector table: each row is one cycle; outputs reflect state before that cycle's edge.
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      req0_valid = tbl[i].v0; req0_data = tbl[i].d0; req0_last = 1'b1;
      req1_valid = tbl[i].v1; req1_data = tbl[i].d1; req1_last = 1'b1;
      tx_ready   = tbl[i].txr;
      @(negedge clk);
      check($sformatf("v%0d_r0", i), {31'd0, req0_ready}, {31'd0, tbl[i].r0});
      check($sformatf("v%0d_r1", i), {31'd0, req1_ready}, {31'd0, tbl[i].r1});
      check($sformatf("v%0d_txv", i), {31'd0, tx_valid}, {31'd0, tbl[i].txv});
      check($sformatf("v%0d_txd", i), {24'd0, tx_data}, {24'd0, tbl[i].txd});
      check($sformatf("v%0d_src", i), {30'd0, src}, {30'd0, tbl[i].src});
      if (tbl[i].r0) exp_q.push_back({tbl[i].d0, 2'b01});
      if (tbl[i].r1) exp_q.push_back({tbl[i].d1, 2'b10});
    end
    drain("table");

    // Both requesters streaming: strict alternation starting with req0.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      s0_d[k] = 8'h50 + 8'(k); s0_l[k] = 1'b1;
      s1_d[k] = 8'h60 + 8'(k); s1_l[k] = 1'b1;
      exp_q.push_back({s0_d[k], 2'b01});
      exp_q.push_back({s1_d[k], 2'b10});
    end
    run_streams(3, 3, "rr");
    drain("rr");

    // Three-byte message from req0 against a single byte from req1.
    do_reset();
    s0_d[0] = 8'h10; s0_l[0] = 1'b0;
    s0_d[1] = 8'h11; s0_l[1] = 1'b0;
    s0_d[2] = 8'h12; s0_l[2] = 1'b1;
    s1_d[0] = 8'h20; s1_l[0] = 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
    exp_q.push_back({8'h10, 2'b01});
    exp_q.push_back({8'h11, 2'b01});
    exp_q.push_back({8'h12, 2'b01});
    exp_q.push_back({8'h20, 2'b10});
`else
    exp_q.push_back({8'h10, 2'b01});
    exp_q.push_back({8'h20, 2'b10});
    exp_q.push_back({8'h11, 2'b01});
    exp_q.push_back({8'h12, 2'b01});
`endif
    run_streams(3, 1, "msg");
    drain("msg");

    // Transmitter stalls for 5 cycles while holding 0x55.
    do_reset();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 8'h55; req0_last = 1'b1; tx_ready = 1'b0;
    @(negedge clk);
    check("stall_accept55", {31'd0, req0_ready}, 1);
    exp_q.push_back({8'h55, 2'b01});
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_data = 8'h56;
      req1_valid = 1'b1; req1_data = 8'h66; req1_last = 1'b1;
      tx_ready = 1'b0;
      @(negedge clk);
      check($sformatf("stall%0d_txd", k), {24'd0, tx_data}, 32'h55);
      check($sformatf("stall%0d_src", k), {30'd0, src}, 32'h1);
      check($sformatf("stall%0d_txv", k), {31'd0, tx_valid}, 1);
      check($sformatf("stall%0d_rdy", k), {30'd0, req1_ready, req0_ready}, 0);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(negedge clk);
    check("release_r1", {31'd0, req1_ready}, 1);
    check("release_r0", {31'd0, req0_ready}, 0);
    exp_q.push_back({8'h66, 2'b10});
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; tx_ready = 1'b0;
    @(negedge clk);
    check("release_txd", {24'd0, tx_data}, 32'h66);
    check("release_src", {30'd0, src}, 32'h2);
    drain("stall");

    // Reset while a non-final byte from req0 is held.
    do_reset();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 8'h30; req0_last = 1'b0; tx_ready = 1'b0;
    @(negedge clk);
    check("mid_accept30", {31'd0, req0_ready}, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 8'h70; req1_last = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_rdy", {30'd0, req1_ready, req0_ready}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_post_txv", {31'd0, tx_valid}, 0);
    check("mid_post_src", {30'd0, src}, 0);
    check("mid_post_txd", {24'd0, tx_data}, 0);
    check("mid_post_r1", {31'd0, req1_ready}, 1);
    exp_q.push_back({8'h70, 2'b10});
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    check("mid_held70", {24'd0, tx_data}, 32'h70);
    check("mid_src70", {30'd0, src}, 32'h2);
    drain("mid");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
